// File: rtl/rvl_mbox_cmd_engine.sv
// rvl_mbox_cmd_engine
//   User-side command engine and sole master of port B of the shared RAM.
//   It polls the mailbox word at address 0. When GO is set, it reads the
//   SRC/LEN/DST arguments and range-checks them. It then runs FILL, CHECKSUM
//   or COPY over the RAM, and writes RESULT (addr 4) followed by the status
//   word (addr 0).
// Ports
//   usr_clk, usr_rst     : clock, synchronous active-high reset
//   enable               : polling allowed (only looked at while idle)
//   usr_ce/usr_we        : port B access strobe / write qualifier
//   usr_addr/usr_wdata   : port B word address / write data
//   usr_rdata            : port B read data, valid the cycle after the access
//   busy, done, err      : command in flight / status-write pulse / sticky error
module rvl_mbox_cmd_engine #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int POLL_CYCLES = 256
) (
    input  logic                  usr_clk,
    input  logic                  usr_rst,
    input  logic                  enable,
    output logic                  usr_ce,
    output logic                  usr_we,
    output logic [ADDR_WIDTH-1:0] usr_addr,
    output logic [DATA_WIDTH-1:0] usr_wdata,
    input  logic [DATA_WIDTH-1:0] usr_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [2:0] {
        S_IDLE, S_POLL_RD, S_POLL_CHK, S_ARG_RD, S_CHECK, S_EXEC, S_WB_RES, S_WB_CMD
    } state_t;

    localparam int CNT_W = $clog2(POLL_CYCLES + 1);
    localparam int LW    = ADDR_WIDTH + 1;  // holds any legal LEN (up to 2**ADDR_WIDTH)
    localparam int SW    = ADDR_WIDTH + 2;  // start + length never wraps at this width
    localparam logic [SW-1:0]         DEPTH      = {2'b01, {ADDR_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MBOX_WORDS = DATA_WIDTH'(8);
    localparam logic [3:0] OP_FILL = 4'd1;
    localparam logic [3:0] OP_SUM  = 4'd2;
    localparam logic [3:0] OP_COPY = 4'd3;

    state_t                  state_q;
    logic [CNT_W-1:0]        poll_cnt_q;
    logic [1:0]              arg_idx_q;
    logic [3:0]              op_q;
    logic [DATA_WIDTH-1:0]   src_q, len_q, dst_q, acc_q;
    logic [LW-1:0]           idx_q;
    logic                    phase_q;
    logic                    ce_q, we_q, copy_wr_q, busy_q, done_q, err_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    // Derived values used by the FSM
    logic [LW-1:0]         len_lo, idx_d;
    logic [SW-1:0]         src_end, dst_end;
    logic                  src_bad, dst_bad, len_bad, op_bad, cmd_err, len_zero;
    logic [DATA_WIDTH-1:0] acc_d, cmd_word;

    assign len_lo   = len_q[ADDR_WIDTH:0];
    assign idx_d    = idx_q + LW'(1);
    assign acc_d    = acc_q + usr_rdata;
    assign src_end  = {2'b00, src_q[ADDR_WIDTH-1:0]} + {1'b0, len_lo};
    assign dst_end  = {2'b00, dst_q[ADDR_WIDTH-1:0]} + {1'b0, len_lo};
    assign src_bad  = (src_q[DATA_WIDTH-1:ADDR_WIDTH] != '0) || (src_q < MBOX_WORDS) ||
                      (src_end > DEPTH);
    assign dst_bad  = (dst_q[DATA_WIDTH-1:ADDR_WIDTH] != '0) || (dst_q < MBOX_WORDS) ||
                      (dst_end > DEPTH);
    assign len_bad  = (len_q[DATA_WIDTH-1:ADDR_WIDTH+1] != '0);
    assign op_bad   = (op_q != OP_FILL) && (op_q != OP_SUM) && (op_q != OP_COPY);
    assign cmd_err  = op_bad || src_bad || len_bad || ((op_q == OP_COPY) && dst_bad);
    assign len_zero = (len_q == '0);
    assign cmd_word = DATA_WIDTH'({1'b0, 1'b1, err_q, 25'd0, op_q});

    always_ff @(posedge usr_clk) begin
        if (usr_rst) begin
            state_q    <= S_IDLE;
            poll_cnt_q <= '0;
            arg_idx_q  <= '0;
            op_q       <= '0;
            src_q      <= '0;
            len_q      <= '0;
            dst_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            phase_q    <= 1'b0;
            ce_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            copy_wr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Port B is idle and quiet unless a branch below issues an access.
            ce_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            copy_wr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        if (poll_cnt_q >= CNT_W'(POLL_CYCLES - 1)) begin
                            poll_cnt_q <= '0;
                            ce_q       <= 1'b1;
                            state_q    <= S_POLL_RD;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + CNT_W'(1);
                        end
                    end
                end
                // The interval counter keeps running through the two poll
                // cycles so consecutive mailbox reads are POLL_CYCLES apart.
                S_POLL_RD: begin
                    poll_cnt_q <= poll_cnt_q + CNT_W'(1);
                    state_q    <= S_POLL_CHK;
                end
                S_POLL_CHK: begin
                    if (usr_rdata[31]) begin
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        op_q      <= usr_rdata[3:0];
                        ce_q      <= 1'b1;
                        addr_q    <= ADDR_WIDTH'(1);
                        arg_idx_q <= '0;
                        state_q   <= S_ARG_RD;
                    end else begin
                        poll_cnt_q <= poll_cnt_q + CNT_W'(1);
                        state_q    <= S_IDLE;
                    end
                end
                // Pipelined argument fetch: cycle k presents addr k+1 and
                // receives the data of addr k.
                S_ARG_RD: begin
                    case (arg_idx_q)
                        2'd1:    src_q <= usr_rdata;
                        2'd2:    len_q <= usr_rdata;
                        2'd3:    dst_q <= usr_rdata;
                        default: ;
                    endcase
                    if (arg_idx_q <= 2'd1) begin
                        ce_q   <= 1'b1;
                        addr_q <= ADDR_WIDTH'({1'b0, arg_idx_q} + 3'd2);
                    end
                    if (arg_idx_q == 2'd3) begin
                        state_q <= S_CHECK;
                    end else begin
                        arg_idx_q <= arg_idx_q + 2'd1;
                    end
                end
                S_CHECK: begin
                    idx_q   <= '0;
                    phase_q <= 1'b0;
                    acc_q   <= '0;
                    if (cmd_err || len_zero) begin
                        err_q   <= cmd_err;
                        ce_q    <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= ADDR_WIDTH'(4);
                        state_q <= S_WB_RES;
                    end else begin
                        ce_q    <= 1'b1;
                        we_q    <= (op_q == OP_FILL);
                        addr_q  <= src_q[ADDR_WIDTH-1:0];
                        wdata_q <= (op_q == OP_FILL) ? dst_q : '0;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_FILL: begin
                            ce_q <= 1'b1;
                            we_q <= 1'b1;
                            if (idx_d < len_lo) begin
                                addr_q  <= src_q[ADDR_WIDTH-1:0] + idx_d[ADDR_WIDTH-1:0];
                                wdata_q <= dst_q;
                                idx_q   <= idx_d;
                            end else begin
                                addr_q  <= ADDR_WIDTH'(4);
                                wdata_q <= len_q;
                                state_q <= S_WB_RES;
                            end
                        end
                        // Cycle i presents read i and receives read i-1.
                        OP_SUM: begin
                            if (idx_q != '0) begin
                                acc_q <= acc_d;
                            end
                            if (idx_q == len_lo) begin
                                ce_q    <= 1'b1;
                                we_q    <= 1'b1;
                                addr_q  <= ADDR_WIDTH'(4);
                                wdata_q <= acc_d;
                                state_q <= S_WB_RES;
                            end else begin
                                if (idx_d < len_lo) begin
                                    ce_q   <= 1'b1;
                                    addr_q <= src_q[ADDR_WIDTH-1:0] + idx_d[ADDR_WIDTH-1:0];
                                end
                                idx_q <= idx_d;
                            end
                        end
                        default: begin  // COPY: read word, then write it
                            ce_q <= 1'b1;
                            if (!phase_q) begin
                                we_q      <= 1'b1;
                                addr_q    <= dst_q[ADDR_WIDTH-1:0] + idx_q[ADDR_WIDTH-1:0];
                                copy_wr_q <= 1'b1;
                                phase_q   <= 1'b1;
                            end else if (idx_d < len_lo) begin
                                addr_q  <= src_q[ADDR_WIDTH-1:0] + idx_d[ADDR_WIDTH-1:0];
                                idx_q   <= idx_d;
                                phase_q <= 1'b0;
                            end else begin
                                we_q    <= 1'b1;
                                addr_q  <= ADDR_WIDTH'(4);
                                wdata_q <= len_q;
                                state_q <= S_WB_RES;
                            end
                        end
                    endcase
                end
                S_WB_RES: begin
                    ce_q    <= 1'b1;
                    we_q    <= 1'b1;
                    addr_q  <= '0;
                    wdata_q <= cmd_word;
                    done_q  <= 1'b1;
                    state_q <= S_WB_CMD;
                end
                S_WB_CMD: begin
                    busy_q     <= 1'b0;
                    poll_cnt_q <= '0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign usr_ce = ce_q;
    assign usr_we = we_q;
    assign usr_addr = addr_q;
    // A COPY write forwards the word read on the previous cycle straight from
    // the RAM output. This keeps the loop at 2 cycles per word.
    assign usr_wdata = copy_wr_q ? usr_rdata : wdata_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
endmodule

// File: tb/tb_rvl_mbox_cmd_engine.sv
module tb_rvl_mbox_cmd_engine;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int PC = 16;

    logic          usr_clk = 1'b0;
    logic          usr_rst = 1'b1;
    logic          enable  = 1'b0;
    logic          usr_ce, usr_we, busy, done, err;
    logic [AW-1:0] usr_addr;
    logic [DW-1:0] usr_wdata;
    logic [DW-1:0] usr_rdata = '0;

    always #5 usr_clk = ~usr_clk;

    rvl_mbox_cmd_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_CYCLES(PC)) dut (
        .usr_clk(usr_clk), .usr_rst(usr_rst), .enable(enable),
        .usr_ce(usr_ce), .usr_we(usr_we), .usr_addr(usr_addr),
        .usr_wdata(usr_wdata), .usr_rdata(usr_rdata),
        .busy(busy), .done(done), .err(err)
    );

    // Shared RAM model: port A = host (bench), port B = DUT, 1-cycle read latency.
    bit   [DW-1:0] mem [0:(1<<AW)-1];
    logic          ha_we = 1'b0;
    logic [AW-1:0] ha_addr = '0;
    logic [DW-1:0] ha_wdata = '0;

    always @(posedge usr_clk) begin
        if (ha_we) mem[ha_addr] <= ha_wdata;
        if (usr_ce) begin
            if (usr_we) mem[usr_addr] <= usr_wdata;
            usr_rdata <= mem[usr_addr];
        end
    end

    // Port B activity monitor
    int acc_cnt = 0, data_wr = 0, poll_rd = 0, done_cnt = 0;
    int cyc = 0, last_poll = 0, poll_int = 0;
    always @(negedge usr_clk) begin
        cyc++;
        if (usr_ce === 1'b1) begin
            acc_cnt++;
            if (usr_we && usr_addr != 0 && usr_addr != 4) data_wr++;
            if (!usr_we && usr_addr == 0) begin
                if (poll_rd > 0) poll_int = cyc - last_poll;
                last_poll = cyc;
                poll_rd++;
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge usr_clk);
        #1;
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ha_addr  = a;
        ha_wdata = d;
        ha_we    = 1'b1;
        step();
        ha_we    = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] op,
                           input logic [DW-1:0] src, input logic [DW-1:0] len,
                           input logic [DW-1:0] dst);
        bit seen;
        int d0;
        host_wr(AW'(1), src);
        host_wr(AW'(2), len);
        host_wr(AW'(3), dst);
        d0 = done_cnt;
        host_wr(AW'(0), 32'h8000_0000 | DW'(op));
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            step();
            if (done === 1'b1) seen = 1;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        step();
        check({tag, "_busy_drop"}, 64'(busy), 64'd0);
        check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
        $display("cmd %s op=%0d src=0x%0h len=%0d dst=0x%0h -> status=0x%08h result=0x%08h err=%0b",
                 tag, op, src, len, dst, mem[0], mem[4], err);
    endtask

    initial begin
        int w0, a0, p1;
        bit seen;

        // Reset state
        repeat (4) step();
        check("rst_ctl", 64'({usr_ce, usr_we, busy, done, err}), 64'd0);
        check("rst_addr", 64'(usr_addr), 64'd0);
        check("rst_wdata", 64'(usr_wdata), 64'd0);
        usr_rst = 1'b0;
        enable  = 1'b1;

        // FILL
        w0 = data_wr;
        run_cmd("fill", 4'd1, 32'h10, 32'd4, 32'hA5A5_A5A5);
        for (int i = 0; i < 4; i++) check("fill_word", 64'(mem[16'h10 + i]), 64'hA5A5_A5A5);
        check("fill_after_end", 64'(mem[16'h14]), 64'd0);
        check("fill_result", 64'(mem[4]), 64'd4);
        check("fill_status", 64'(mem[0]), 64'h4000_0001);
        check("fill_err", 64'(err), 64'd0);
        check("fill_nwr", 64'(data_wr - w0), 64'd4);

        // FILL of the very last RAM word (SRC+LEN == depth is legal)
        run_cmd("fill_top", 4'd1, 32'hFFFF, 32'd1, 32'h0BAD_F00D);
        check("fill_top_word", 64'(mem[16'hFFFF]), 64'h0BAD_F00D);
        check("fill_top_status", 64'(mem[0]), 64'h4000_0001);

        // CHECKSUM with wrap
        host_wr(AW'('h20), 32'd1);
        host_wr(AW'('h21), 32'd2);
        host_wr(AW'('h22), 32'hFFFF_FFFF);
        w0 = data_wr;
        run_cmd("sum", 4'd2, 32'h20, 32'd3, 32'd0);
        check("sum_result", 64'(mem[4]), 64'h2);
        check("sum_status", 64'(mem[0]), 64'h4000_0002);
        check("sum_nwr", 64'(data_wr - w0), 64'd0);

        // COPY
        host_wr(AW'('h30), 32'h11);
        host_wr(AW'('h31), 32'h22);
        run_cmd("copy", 4'd3, 32'h30, 32'd2, 32'h40);
        check("copy_w0", 64'(mem[16'h40]), 64'h11);
        check("copy_w1", 64'(mem[16'h41]), 64'h22);
        check("copy_after_end", 64'(mem[16'h42]), 64'd0);
        check("copy_result", 64'(mem[4]), 64'd2);
        check("copy_status", 64'(mem[0]), 64'h4000_0003);

        // Error cases: result forced to 0, no data words touched
        host_wr(AW'(4), 32'h1234_5678);
        w0 = data_wr;
        run_cmd("err_src_low", 4'd1, 32'h4, 32'd1, 32'hDEAD);
        check("err_src_low_status", 64'(mem[0]), 64'h6000_0001);
        check("err_src_low_result", 64'(mem[4]), 64'd0);
        check("err_src_low_err", 64'(err), 64'd1);
        check("err_src_low_nwr", 64'(data_wr - w0), 64'd0);

        host_wr(AW'(4), 32'h1234_5678);
        w0 = data_wr;
        run_cmd("err_src_end", 4'd1, 32'hFFFF, 32'd2, 32'hDEAD);
        check("err_src_end_status", 64'(mem[0]), 64'h6000_0001);
        check("err_src_end_result", 64'(mem[4]), 64'd0);
        check("err_src_end_nwr", 64'(data_wr - w0), 64'd0);
        check("err_src_end_word", 64'(mem[16'hFFFF]), 64'h0BAD_F00D);

        host_wr(AW'(4), 32'h1234_5678);
        w0 = data_wr;
        run_cmd("err_op", 4'd7, 32'h10, 32'd1, 32'h0);
        check("err_op_status", 64'(mem[0]), 64'h6000_0007);
        check("err_op_result", 64'(mem[4]), 64'd0);
        check("err_op_nwr", 64'(data_wr - w0), 64'd0);

        w0 = data_wr;
        run_cmd("err_dst_low", 4'd3, 32'h30, 32'd1, 32'h2);
        check("err_dst_low_status", 64'(mem[0]), 64'h6000_0003);
        check("err_dst_low_nwr", 64'(data_wr - w0), 64'd0);
        repeat (5) step();
        check("err_sticky", 64'(err), 64'd1);

        // LEN=0: completes cleanly and clears err
        host_wr(AW'(4), 32'h1234_5678);
        w0 = data_wr;
        run_cmd("len0", 4'd1, 32'h10, 32'd0, 32'hFFFF_0000);
        check("len0_status", 64'(mem[0]), 64'h4000_0001);
        check("len0_result", 64'(mem[4]), 64'd0);
        check("len0_err", 64'(err), 64'd0);
        check("len0_nwr", 64'(data_wr - w0), 64'd0);

        // Reset in the middle of a FILL
        host_wr(AW'(4), 32'hCAFE_0004);
        host_wr(AW'(1), 32'h100);
        host_wr(AW'(2), 32'd50);
        host_wr(AW'(3), 32'h5A);
        w0 = data_wr;
        host_wr(AW'(0), 32'h8000_0001);
        seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            step();
            if (data_wr - w0 >= 3) seen = 1;
        end
        check("rst_mid_reached", 64'(seen), 64'd1);
        usr_rst = 1'b1;
        enable  = 1'b0;
        step();
        check("rst_mid_ctl", 64'({usr_ce, usr_we, busy, done, err}), 64'd0);
        check("rst_mid_addr", 64'(usr_addr), 64'd0);
        check("rst_mid_wdata", 64'(usr_wdata), 64'd0);
        step();
        step();
        usr_rst = 1'b0;
        a0 = acc_cnt;
        repeat (100) step();
        check("rst_mid_quiet", 64'(acc_cnt - a0), 64'd0);
        check("rst_mid_cmd_kept", 64'(mem[0]), 64'h8000_0001);
        check("rst_mid_res_kept", 64'(mem[4]), 64'hCAFE_0004);
        check("rst_mid_partial", 64'(mem[16'h100]), 64'h5A);
        check("rst_mid_tail", 64'(mem[16'h131]), 64'd0);
        $display("reset mid-FILL: status=0x%08h result=0x%08h", mem[0], mem[4]);
        host_wr(AW'(0), 32'h0);

        // Polling behaviour
        a0 = acc_cnt;
        repeat (1000) step();
        check("poll_disabled", 64'(acc_cnt - a0), 64'd0);
        enable = 1'b1;
        p1 = poll_rd;
        seen = 0;
        for (int i = 0; i < 10 * PC && !seen; i++) begin
            step();
            if (poll_rd - p1 >= 2) seen = 1;
        end
        check("poll_started", 64'(seen), 64'd1);
        p1 = poll_rd;
        a0 = acc_cnt;
        repeat (10 * PC) step();
        check("poll_count", 64'(poll_rd - p1), 64'd10);
        check("poll_only_reads", 64'(acc_cnt - a0), 64'd10);
        check("poll_interval", 64'(poll_int), 64'(PC));
        $display("polling: %0d reads in %0d cycles, interval %0d", poll_rd - p1, 10 * PC, poll_int);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
